dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Arbitrates the data-side BRAM port (port B) between the pipeline's MEM stage and an external requester (program loader / debug master), one access per cycle. It owns the port-B address, byte-write-enable and write-data signals. It routes the one-cycle-latency read data back to whichever requester issued the read. It raises a pipeline stall whenever the MEM stage is denied, and it guarantees the external requester cannot be starved.

## Interface
Parameters:
- STARVE_LIMIT, default 8: consecutive denied external-request cycles before the external requester is forced a grant; legal range 1–255.
- CNT_W, default 8: width of the starvation counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  MEM-stage access request (load or store).
- cpu_we  in  4  byte write enables; 0 means read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_rvalid  out  1  read data valid on cpu_rdata.
- cpu_rdata  out  32  read word.
- stall  out  1  freeze the IF/ID/EX/MEM pipeline registers.
- ext_req, ext_we[4], ext_addr[32], ext_wdata[32], ext_gnt, ext_rvalid, ext_rdata[32]: the same meanings for the external requester.
- bram_addrb  out  32  to BRAM port B.
- bram_web  out  4  to BRAM port B.
- bram_dib  out  32  to BRAM port B.
- bram_dob  in  32  from BRAM port B, valid one cycle after the address.

## Operation
- At most one of cpu_gnt and ext_gnt is high in any cycle.
- Grants are combinational from the requests and the registered arbitration state.
- Port mux:
  - granted requester's addr/we/wdata drive bram_addrb/bram_web/bram_dib;
  - with no grant, bram_web=0, bram_addrb holds its last value, bram_dib=0.
- Conflict (cpu_req and ext_req both high), fixed priority:
  - CPU wins unless starve_cnt == STARVE_LIMIT;
  - at the limit, the external requester wins for exactly one cycle.
- starve_cnt, CNT_W bits:
  - increments, saturating at STARVE_LIMIT, on each cycle where ext_req=1 and ext_gnt=0;
  - clears on any ext_gnt or when ext_req=0.
- Read tag:
  - 2-bit register rd_tag={cpu,ext} set to the granted requester when the granted we==0, else 00;
  - next cycle, the tagged requester's rvalid=1 and its rdata=bram_dob;
  - untagged rdata=0.
- Writes produce no rvalid. A write completes in its grant cycle.
- stall = cpu_req & ~cpu_gnt.
- Requester rule: req, we, addr and wdata hold stable until gnt. Dropping req before gnt is legal; the request is abandoned with no side effect.
- Reset mid-operation clears rd_tag, so a read granted in the cycle before reset produces no rvalid.

## Timing
- Reset values:
  - cpu_gnt=0, ext_gnt=0, cpu_rvalid=0, ext_rvalid=0, cpu_rdata=0, ext_rdata=0;
  - bram_web=0, bram_addrb=0, bram_dib=0;
  - stall=0, starve_cnt=0, rd_tag=00, rr_last=0.
- Grant latency: 0 cycles, same cycle as req.
- Read latency: rvalid exactly 1 cycle after the granted read cycle.
- Back-to-back grants to the same or alternating requesters are allowed every cycle, giving full throughput.
- Forced external grant: with CPU continuously requesting, at most STARVE_LIMIT consecutive denied cycles, then 1 ext grant. Worst-case external wait is STARVE_LIMIT+1 cycles.
- Single requester: always granted immediately, regardless of starve_cnt.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - conflict resolution becomes round-robin;
  - a one-bit register rr_last records the last conflict winner, and the other requester wins the next conflict;
  - starve_cnt and the STARVE_LIMIT logic are compiled out, and starvation is bounded at 1 cycle.
- ARB_ROUND_ROBIN_EN undefined: fixed CPU priority with the starvation counter as described above.

## Test plan
- Reset then cpu_req=1, cpu_we=0, cpu_addr=0x40, BRAM word 0x40=0xDEADBEEF:
  - cpu_gnt=1 in the same cycle;
  - next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, ext_rvalid=0.
- ext_req=1, ext_we=4'b0011, ext_addr=0x100, ext_wdata=0x0000ABCD, CPU idle:
  - ext_gnt=1, bram_web=4'b0011, bram_addrb=0x100, stall=0;
  - a subsequent CPU read of 0x100 returns low half 0xABCD.
- Fixed priority, STARVE_LIMIT=8, cpu_req and ext_req held high for 20 cycles:
  - cycles 0–7 cpu_gnt with stall=0, cycle 8 ext_gnt with stall=1, cycles 9–16 cpu_gnt, cycle 17 ext_gnt.
- ARB_ROUND_ROBIN_EN, both requesting for 6 cycles from reset:
  - grants alternate cpu, ext, cpu, ext, cpu, ext;
  - stall=1 on the ext cycles.
- Back-to-back reads, CPU at cycle n, ext at cycle n+1:
  - cpu_rvalid only at n+1, ext_rvalid only at n+2;
  - each rdata matches its own address's word.
- Read granted at cycle n, rst_n asserted at n+1:
  - cpu_rvalid stays 0, and all outputs are at their reset values while in reset.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares BRAM port B between the MEM stage and an external master.
// Define ARB_ROUND_ROBIN_EN for round-robin conflicts instead of CPU priority + starvation limit.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  input  logic        ext_req,
  input  logic [3:0]  ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [31:0] bram_addrb,
  output logic [3:0]  bram_web,
  output logic [31:0] bram_dib,
  input  logic [31:0] bram_dob
);

  logic [1:0]  rd_tag;
  logic [31:0] addr_q;
  logic        cpu_win;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;

  assign cpu_win = ~rr_last;

  // Remember who won the last conflict; the other side wins the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b0;
    end else if (cpu_req && ext_req) begin
      rr_last <= cpu_gnt;
    end
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign cpu_win = (starve_cnt != LIMIT);

  // Count consecutive denied external cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!ext_req || ext_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  // Grant decision and port mux; idle port parks on the last address.
  always_comb begin
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    bram_addrb = addr_q;
    bram_web   = 4'b0000;
    bram_dib   = 32'h0;
    if (rst_n) begin
      cpu_gnt = cpu_req && (!ext_req || cpu_win);
      ext_gnt = ext_req && !cpu_gnt;
    end
    unique case (1'b1)
      cpu_gnt: begin
        bram_addrb = cpu_addr;
        bram_web   = cpu_we;
        bram_dib   = cpu_wdata;
      end
      ext_gnt: begin
        bram_addrb = ext_addr;
        bram_web   = ext_we;
        bram_dib   = ext_wdata;
      end
      default: ;
    endcase
  end

  assign stall = rst_n && cpu_req && !cpu_gnt;

  // Hold the port address and tag the owner of a granted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 32'h0;
      rd_tag <= 2'b00;
    end else begin
      addr_q <= bram_addrb;
      rd_tag <= {cpu_gnt && (cpu_we == 4'b0000),
                 ext_gnt && (ext_we == 4'b0000)};
    end
  end

  assign cpu_rvalid = rd_tag[1];
  assign ext_rvalid = rd_tag[0];
  assign cpu_rdata  = rd_tag[1] ? bram_dob : 32'h0;
  assign ext_rdata  = rd_tag[0] ? bram_dob : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: BRAM model plus read-data scoreboard.
// Tasks drive each scenario; a negedge monitor pops expected read words.
module tb_dmem_port_arbiter;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, ext_req;
  logic [3:0]  cpu_we, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, stall;
  logic [31:0] cpu_rdata, ext_rdata;
  logic [31:0] bram_addrb, bram_dib, bram_dob;
  logic [3:0]  bram_web;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        init_done = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t ext_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dmem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .bram_addrb(bram_addrb), .bram_web(bram_web),
    .bram_dib(bram_dib), .bram_dob(bram_dob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + i * 32'h0001_0101;
  endfunction

  // Synchronous BRAM port B, read-first, one cycle latency.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= (i == 16) ? 32'hDEADBEEF : init_word(i);
      end
      init_done <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bram_web[b]) mem[bram_addrb[11:2]][b*8 +: 8] <= bram_dib[b*8 +: 8];
      end
    end
    bram_dob <= mem[bram_addrb[11:2]];
  end

  // Scoreboard: pop expected read data when a DUT rvalid appears.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (cpu_rvalid === 1'b1) begin
        checks++;
        if (cpu_q.size() == 0) begin
          errors++;
          $display("FAIL cpu_rvalid_unexpected cyc=%0d got=1 want=0", cyc);
        end else begin
          e = cpu_q.pop_front();
          if (e.due != cyc || cpu_rdata !== e.data) begin
            errors++;
            $display("FAIL cpu_rdata cyc=%0d got=%h want=%h due=%0d",
                     cyc, cpu_rdata, e.data, e.due);
          end
        end
      end else begin
        checks++;
        if (cpu_rdata !== 32'h0) begin
          errors++;
          $display("FAIL cpu_rdata_idle got=%h want=0", cpu_rdata);
        end
        if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL cpu_rvalid_missing cyc=%0d got=0 want=1", cyc);
          e = cpu_q.pop_front();
        end
      end
      if (ext_rvalid === 1'b1) begin
        checks++;
        if (ext_q.size() == 0) begin
          errors++;
          $display("FAIL ext_rvalid_unexpected cyc=%0d got=1 want=0", cyc);
        end else begin
          e = ext_q.pop_front();
          if (e.due != cyc || ext_rdata !== e.data) begin
            errors++;
            $display("FAIL ext_rdata cyc=%0d got=%h want=%h due=%0d",
                     cyc, ext_rdata, e.data, e.due);
          end
        end
      end else begin
        checks++;
        if (ext_rdata !== 32'h0) begin
          errors++;
          $display("FAIL ext_rdata_idle got=%h want=0", ext_rdata);
        end
        if (ext_q.size() > 0 && ext_q[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL ext_rvalid_missing cyc=%0d got=0 want=1", cyc);
          e = ext_q.pop_front();
        end
      end
    end
  end

  task automatic drive(input logic cr, input logic [3:0] cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic [3:0] ew,
                       input logic [31:0] ea, input logic [31:0] ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, stall, bram_web} !== 9'h0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0",
               {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, stall, bram_web});
    end
    checks++;
    if ({bram_addrb, bram_dib, cpu_rdata, ext_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got=%h %h %h %h want=0",
               bram_addrb, bram_dib, cpu_rdata, ext_rdata);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if ({cpu_gnt, ext_gnt, stall} !== 3'b100 || bram_addrb !== 32'h40) begin
      errors++;
      $display("FAIL cpu_read_gnt got=%b addr=%h want=100 addr=40",
               {cpu_gnt, ext_gnt, stall}, bram_addrb);
    end
    cpu_q.push_back('{cyc + 1, ref_mem[16]});
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || ext_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_data got=%b %h %b want=1 deadbeef 0",
               cpu_rvalid, cpu_rdata, ext_rvalid);
    end
  endtask

  task automatic test_ext_write();
    @(negedge clk);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, 32'h100, 32'h0000ABCD);
    #1;
    checks++;
    if ({ext_gnt, cpu_gnt, stall} !== 3'b100 || bram_web !== 4'b0011 ||
        bram_addrb !== 32'h100 || bram_dib !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL ext_write_port got=%b web=%b a=%h d=%h want=100 0011 100 abcd",
               {ext_gnt, cpu_gnt, stall}, bram_web, bram_addrb, bram_dib);
    end
    ref_mem[64] = {ref_mem[64][31:16], 16'hABCD};
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bram_web !== 4'h0 || bram_addrb !== 32'h100 || bram_dib !== 32'h0) begin
      errors++;
      $display("FAIL idle_port got=%b %h %h want=0 100 0",
               bram_web, bram_addrb, bram_dib);
    end
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    cpu_q.push_back('{cyc + 1, ref_mem[64]});
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (cpu_rdata[15:0] !== 16'hABCD) begin
      errors++;
      $display("FAIL ext_write_readback got=%h want=abcd", cpu_rdata[15:0]);
    end
  endtask

  task automatic test_conflict();
    logic exp_cpu;
    int n;
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    n = 6;
`else
    n = 20;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_cpu = (i % 2) == 0;
`else
      exp_cpu = (i % (LIM + 1)) != LIM;
`endif
      checks++;
      if ({cpu_gnt, ext_gnt, stall} !== {exp_cpu, !exp_cpu, !exp_cpu}) begin
        errors++;
        $display("FAIL conflict_c%0d got=%b want=%b", i,
                 {cpu_gnt, ext_gnt, stall}, {exp_cpu, !exp_cpu, !exp_cpu});
      end
      if (exp_cpu) cpu_q.push_back('{cyc + 1, ref_mem[16]});
      else         ext_q.push_back('{cyc + 1, ref_mem[64]});
    end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL b2b_cpu_gnt got=%b want=1", cpu_gnt);
    end
    cpu_q.push_back('{cyc + 1, ref_mem[16]});
    @(negedge clk);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
    #1;
    checks++;
    if ({ext_gnt, cpu_rvalid, ext_rvalid} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_n1 got=%b want=110", {ext_gnt, cpu_rvalid, ext_rvalid});
    end
    ext_q.push_back('{cyc + 1, ref_mem[128]});
    @(negedge clk);
    idle();
    #1;
    checks++;
    if ({cpu_rvalid, ext_rvalid} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_n2 got=%b want=01", {cpu_rvalid, ext_rvalid});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_gnt got=%b want=1", cpu_gnt);
    end
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, stall, bram_web} !== 9'h0 ||
        {bram_addrb, bram_dib, cpu_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b %h %h %h want=0",
               {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, stall, bram_web},
               bram_addrb, bram_dib, cpu_rdata);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rvalid got=%b want=0", cpu_rvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rvalid2 got=%b want=0", cpu_rvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = (i == 16) ? 32'hDEADBEEF : init_word(i);
    end
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_q.size() != 0 || ext_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d want=0/0",
               cpu_q.size(), ext_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
